serial_to_parallel_sync: RTL and testbench

- Receive-side deserializer: consumes the 1-bit serial lane, runs on clk_32f, and recovers 8-bit parallel bytes.
- Aligns to the COM symbol (8'hBC) and declares the lane active after COM_THRESH aligned COMs.
- Then delivers non-COM bytes with a valid flag to the downstream byte-un-striping logic.
- Mirror of the transmit serializer that clk_gen's clocks feed.

---
 rtl/serial_to_parallel_sync_if.sv | 31 +++
 rtl/serial_to_parallel_sync.sv | 129 ++++++++++++
 tb/tb_serial_to_parallel_sync.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_sync_if.sv
// Lane bundle between the serial receive pin and the byte un-striping logic.
// Latency: none (wires only).
// Backpressure: none; the downstream side samples valid_out/data_out each byte period.
//
// Signals:
//   data_in   serial bit into the deserializer, MSB of each byte first
//   data_out  last recovered non-COM byte
//   valid_out data_out is fresh for the current 8-cycle byte period
//   active    lane aligned and locked
interface serial_to_parallel_sync_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    // master: the deserializer itself
    modport master (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

    // slave: the side that feeds serial bits and consumes recovered bytes
    modport slave (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );
endinterface

// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel receive deserializer: aligns on COM, locks after COM_THRESH COMs, emits non-COM bytes.
// Latency: a byte's outputs update on the edge that samples its last bit and hold for 8 edges.
// Backpressure: none; valid_out is a per-byte-period flag, the consumer must keep up with the lane.
//
// Ports:
//   clk_32f  bit clock, all logic on the rising edge
//   reset    synchronous active-low reset (0 = reset)
//   lane     master modport: data_in in, data_out/valid_out/active out
module serial_to_parallel_sync #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned COM_THRESH = 4
) (
    input  logic                      clk_32f,
    input  logic                      reset,
    serial_to_parallel_sync_if.master lane
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    localparam logic [3:0] THRESH = 4'(COM_THRESH);

    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [1:0] state_q,   state_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       active_q,  active_d;

    logic [7:0] shift_next;
    logic       is_com;
    logic       boundary;
    logic [3:0] com_cnt_inc;

    // shift_next already includes this edge's bit, so at a boundary it is the whole byte
    assign shift_next  = {shift_q[6:0], lane.data_in};
    assign is_com      = (shift_next == COM);
    assign boundary    = (bit_cnt_q == 3'd7);
    assign com_cnt_inc = com_cnt_q + 4'd1;

    always_comb begin
        shift_d   = shift_next;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;

        case (state_q)
            ST_SEARCH: begin
                // bit-by-bit hunt; the edge that completes COM defines byte phase
                bit_cnt_d = 3'd0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    if (THRESH == 4'd1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_LOCKING;
                    end
                end
            end

            ST_LOCKING: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc == THRESH) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // drop the byte; its bits stay in shift_q so the hunt can reuse them
                        state_d   = ST_SEARCH;
                        com_cnt_d = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                // no lock-loss detection: only reset leaves ACTIVE
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_com) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = shift_next;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ST_SEARCH;
                bit_cnt_d = 3'd0;
                com_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            state_q   <= ST_SEARCH;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign lane.data_out  = data_q;
    assign lane.valid_out = valid_q;
    assign lane.active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// Bench for serial_to_parallel_sync: drives COM_THRESH=4 and COM_THRESH=1 instances with one bit stream.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; every edge is compared against a stream-level reference model.
module tb_serial_to_parallel_sync;

    localparam logic [7:0] COM = 8'hBC;
    localparam int MAXN = 1024;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    always #5 clk_32f = ~clk_32f;

    serial_to_parallel_sync_if bus4 ();
    serial_to_parallel_sync_if bus1 ();

    serial_to_parallel_sync #(.COM(COM), .COM_THRESH(4)) dut4 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .lane    (bus4)
    );

    serial_to_parallel_sync #(.COM(COM), .COM_THRESH(1)) dut1 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .lane    (bus1)
    );

    int checks   = 0;
    int failures = 0;

    bit         stim [$];
    logic [7:0] e_dat [2][MAXN];
    bit         e_vld [2][MAXN];
    bit         e_act [2][MAXN];
    logic [7:0] o_dat [2][MAXN];
    bit         o_vld [2][MAXN];
    bit         o_act [2][MAXN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
    endtask

    // byte formed by the 8 bits ending at edge i; bits before the segment start are the cleared zeros
    function automatic logic [7:0] win(input int i);
        logic [7:0] w;
        w = 8'h00;
        for (int k = i - 7; k <= i; k++) w = {w[6:0], (k >= 0) ? stim[k] : 1'b0};
        return w;
    endfunction

    // Stream-level model: find the edge where lock completes, then report bytes on 8-edge boundaries.
    task automatic model(input int d, input int thresh, input int n);
        int s, b, cnt, lock;
        logic [7:0] dat;
        bit vld;
        s = 0;
        lock = -1;
        while (s < n && lock < 0) begin
            if (win(s) == COM) begin
                cnt = 1;
                b = s;
                while (cnt < thresh && b + 8 < n && win(b + 8) == COM) begin
                    b += 8;
                    cnt++;
                end
                if (cnt >= thresh) lock = b;
                else s = b + 9;
            end else begin
                s++;
            end
        end
        dat = 8'h00;
        vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (lock >= 0 && i > lock && ((i - lock) % 8) == 0) begin
                if (win(i) != COM) begin
                    dat = win(i);
                    vld = 1'b1;
                end else begin
                    vld = 1'b0;
                end
            end
            e_dat[d][i] = dat;
            e_vld[d][i] = vld;
            e_act[d][i] = (lock >= 0 && i >= lock);
        end
    endtask

    task automatic step(input bit b, input bit rst_n, input int idx);
        @(negedge clk_32f);
        bus4.data_in = b;
        bus1.data_in = b;
        reset = rst_n;
        @(posedge clk_32f);
        #1;
        o_dat[0][idx] = bus4.data_out;
        o_vld[0][idx] = bus4.valid_out;
        o_act[0][idx] = bus4.active;
        o_dat[1][idx] = bus1.data_out;
        o_vld[1][idx] = bus1.valid_out;
        o_act[1][idx] = bus1.active;
    endtask

    task automatic do_reset(input string tag, input int edges);
        for (int i = 0; i < edges; i++) begin
            step(1'($urandom), 1'b0, i);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_rst_dat d%0d e%0d", tag, d, i), 32'(o_dat[d][i]), 32'h00);
                chk($sformatf("%s_rst_vld d%0d e%0d", tag, d, i), 32'(o_vld[d][i]), 32'h0);
                chk($sformatf("%s_rst_act d%0d e%0d", tag, d, i), 32'(o_act[d][i]), 32'h0);
            end
        end
    endtask

    // plays stim from a freshly reset DUT and compares every edge of both instances to the model
    task automatic run_seg(input string tag);
        int n;
        n = stim.size();
        if (n > MAXN) n = MAXN;
        model(0, 4, n);
        model(1, 1, n);
        for (int i = 0; i < n; i++) begin
            step(stim[i], 1'b1, i);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_dat d%0d e%0d", tag, d, i + 1), 32'(o_dat[d][i]), 32'(e_dat[d][i]));
                chk($sformatf("%s_vld d%0d e%0d", tag, d, i + 1), 32'(o_vld[d][i]), 32'(e_vld[d][i]));
                chk($sformatf("%s_act d%0d e%0d", tag, d, i + 1), 32'(o_act[d][i]), 32'(e_act[d][i]));
            end
        end
    endtask

    initial begin
        int any_vld;
        bus4.data_in = 1'b0;
        bus1.data_in = 1'b0;

        // reset hold with random bits
        do_reset("hold", 4);

        // clean lock: junk 101, 4 COMs, 55 AA BC 12 (array index = edge after release - 1)
        stim.delete();
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
        for (int k = 0; k < 4; k++) push_byte(COM);
        push_byte(8'h55); push_byte(8'hAA); push_byte(COM); push_byte(8'h12);
        run_seg("clean");
        chk("clean_act_e34", 32'(o_act[0][33]), 32'h0);
        chk("clean_act_e35", 32'(o_act[0][34]), 32'h1);
        chk("clean_dat_e43", 32'(o_dat[0][42]), 32'h55);
        chk("clean_vld_e43", 32'(o_vld[0][42]), 32'h1);
        chk("clean_vld_e42", 32'(o_vld[0][41]), 32'h0);
        chk("clean_dat_e51", 32'(o_dat[0][50]), 32'hAA);
        chk("clean_vld_e59", 32'(o_vld[0][58]), 32'h0);
        chk("clean_dat_e59", 32'(o_dat[0][58]), 32'hAA);
        chk("clean_dat_e67", 32'(o_dat[0][66]), 32'h12);
        chk("clean_vld_e67", 32'(o_vld[0][66]), 32'h1);

        // lock abort: BC BC 7E then BC x4
        do_reset("abort", 2);
        stim.delete();
        push_byte(COM); push_byte(COM); push_byte(8'h7E);
        for (int k = 0; k < 4; k++) push_byte(COM);
        run_seg("abort");
        any_vld = 0;
        for (int i = 0; i < 56; i++) any_vld += int'(o_vld[0][i]);
        chk("abort_no_vld", 32'(any_vld), 32'h0);
        chk("abort_act_e24", 32'(o_act[0][23]), 32'h0);
        chk("abort_act_e55", 32'(o_act[0][54]), 32'h0);
        chk("abort_act_e56", 32'(o_act[0][55]), 32'h1);

        // misaligned start: 5 zero bits, BC x4, F0
        do_reset("misal", 2);
        stim.delete();
        for (int k = 0; k < 5; k++) stim.push_back(1'b0);
        for (int k = 0; k < 4; k++) push_byte(COM);
        push_byte(8'hF0);
        run_seg("misal");
        chk("misal_act_e37", 32'(o_act[0][36]), 32'h1);
        chk("misal_dat_e45", 32'(o_dat[0][44]), 32'hF0);
        chk("misal_vld_e45", 32'(o_vld[0][44]), 32'h1);

        // threshold 1: BC then 3C
        do_reset("th1", 2);
        stim.delete();
        push_byte(COM); push_byte(8'h3C);
        run_seg("th1");
        chk("th1_act_e7", 32'(o_act[1][6]), 32'h0);
        chk("th1_act_e8", 32'(o_act[1][7]), 32'h1);
        chk("th1_dat_e16", 32'(o_dat[1][15]), 32'h3C);
        chk("th1_vld_e16", 32'(o_vld[1][15]), 32'h1);

        // reset while active with valid_out high, then relock needs 4 COMs again
        do_reset("mid", 1);
        stim.delete();
        for (int k = 0; k < 4; k++) push_byte(COM);
        push_byte(8'h99);
        run_seg("mid_pre");
        chk("mid_pre_vld", 32'(o_vld[0][39]), 32'h1);
        do_reset("mid_pulse", 1);
        stim.delete();
        for (int k = 0; k < 4; k++) push_byte(COM);
        push_byte(8'h22);
        run_seg("mid_post");
        chk("mid_post_act_e31", 32'(o_act[0][30]), 32'h0);
        chk("mid_post_act_e32", 32'(o_act[0][31]), 32'h1);
        chk("mid_post_dat_e40", 32'(o_dat[0][39]), 32'h22);

        // randomized streams: random junk, COM run, random payload
        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("rnd%0d", r), 2);
            stim.delete();
            for (int k = 0; k < int'($urandom_range(0, 12)); k++) stim.push_back(1'($urandom));
            for (int k = 0; k < 4; k++) push_byte(COM);
            for (int k = 0; k < 10; k++) push_byte(((r + k) % 4 == 0) ? COM : 8'($urandom));
            run_seg($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
